// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and constants for the sequential ALU.
// DIVU is only built when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide-by-zero quotient is this bit replicated across the result width.
  localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one iteration per step.
// The divider half exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] res_lo_c,
  output logic [WIDTH-1:0] res_hi_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] op_b;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;

  // Shift-add: conditionally add multiplicand, then shift {hi,lo} right one bit.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_b} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  logic             mode_q;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // Restoring step: shift in the next dividend bit, keep the difference if non-negative.
  always_comb begin
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_b};
    res_lo_c  = mul_lo_n;
    res_hi_c  = mul_hi_n;
    if (mode_q) begin
      if (div_diff[WIDTH]) begin
        res_hi_c = div_shift[WIDTH-1:0];
        res_lo_c = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        res_hi_c = div_diff[WIDTH-1:0];
        res_lo_c = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if (load) begin
      mode_q <= mode;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    res_lo_c = mul_lo_n;
    res_hi_c = mul_hi_n;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      op_b <= '0;
      cnt  <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= a;
      op_b <= b;
      cnt  <= CW'(WIDTH - 1);
    end else if (step) begin
      hi_q <= res_hi_c;
      lo_q <= res_lo_c;
      cnt  <= cnt - CW'(1);
    end
  end

  assign last_c = (cnt == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MULU/DIVU.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise opcode 111 returns zeros.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       selector,
  input  logic [WIDTH-1:0] input_data_A,
  input  logic [WIDTH-1:0] input_data_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] output_data,
  output logic [WIDTH-1:0] output_data_hi,
  output logic             zeroFlag,
  output logic             divZero
);

  state_t           state;
  logic             iter_op_c;
  logic             md_load_c;
  logic             md_mode_c;
  logic             md_last_c;
  logic [WIDTH-1:0] md_lo_c;
  logic [WIDTH-1:0] md_hi_c;
  logic [WIDTH-1:0] single_lo_c;
  logic [WIDTH-1:0] single_hi_c;
  logic             single_dz_c;

  // Single-cycle results and the decision whether the op needs iterations.
  always_comb begin
    single_lo_c = '0;
    single_hi_c = '0;
    single_dz_c = 1'b0;
    iter_op_c   = 1'b0;
    case (selector)
      OP_ADD:  single_lo_c = input_data_A + input_data_B;
      OP_SUB:  single_lo_c = input_data_A - input_data_B;
      OP_AND:  single_lo_c = input_data_A & input_data_B;
      OP_OR:   single_lo_c = input_data_A | input_data_B;
      OP_SLT:  single_lo_c = WIDTH'($signed(input_data_A) < $signed(input_data_B));
      OP_XOR:  single_lo_c = input_data_A ^ input_data_B;
      OP_MULU: iter_op_c   = 1'b1;
      OP_DIVU: begin
`ifdef ALU_SEQ_DIV_EN
        if (input_data_B == '0) begin
          single_lo_c = {WIDTH{DIV_ZERO_QUOT_BIT}};
          single_hi_c = input_data_A;
          single_dz_c = 1'b1;
        end else begin
          iter_op_c = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign md_load_c = (state == ST_IDLE) && start && iter_op_c;
  assign md_mode_c = (selector == OP_DIVU);

  alu_seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clock    (clock),
    .reset    (reset),
    .load     (md_load_c),
    .mode     (md_mode_c),
    .step     (state == ST_ITER),
    .a        (input_data_A),
    .b        (input_data_B),
    .last_c   (md_last_c),
    .res_lo_c (md_lo_c),
    .res_hi_c (md_hi_c)
  );

  // Control FSM; result registers load on entry to DONE and hold afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      output_data    <= '0;
      output_data_hi <= '0;
      zeroFlag       <= 1'b0;
      divZero        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (iter_op_c) begin
              state <= ST_ITER;
            end else begin
              state          <= ST_DONE;
              done           <= 1'b1;
              output_data    <= single_lo_c;
              output_data_hi <= single_hi_c;
              zeroFlag       <= (single_lo_c == '0);
              divZero        <= single_dz_c;
            end
          end
        end
        ST_ITER: begin
          if (md_last_c) begin
            state          <= ST_DONE;
            done           <= 1'b1;
            output_data    <= md_lo_c;
            output_data_hi <= md_hi_c;
            zeroFlag       <= (md_lo_c == '0);
            divZero        <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): cycle-level reference model plus directed vectors.
module tb_alu_seq;

  localparam int unsigned W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic [2:0]    selector;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  output_data;
  logic [W-1:0]  output_data_hi;
  logic          zeroFlag;
  logic          divZero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .selector       (selector),
    .input_data_A   (in_a),
    .input_data_B   (in_b),
    .busy           (busy),
    .done           (done),
    .output_data    (output_data),
    .output_data_hi (output_data_hi),
    .zeroFlag       (zeroFlag),
    .divZero        (divZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation and its start-to-done latency.
  function automatic void model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] lo, output logic [W-1:0] hi,
                                   output logic dz, output int lat);
    logic [63:0] p;
    lo = '0; hi = '0; dz = 1'b0; lat = 1;
    case (op)
      3'd0: lo = a + b;
      3'd1: lo = a - b;
      3'd2: lo = a & b;
      3'd3: lo = a | b;
      3'd4: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: lo = a ^ b;
      3'd6: begin
        p   = {32'd0, a} * {32'd0, b};
        lo  = p[31:0];
        hi  = p[63:32];
        lat = W + 1;
      end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
          dz = 1'b1;
        end else begin
          lo  = a / b;
          hi  = a % b;
          lat = W + 1;
        end
`endif
      end
    endcase
  endfunction

  // Reference model: countdown to completion, no pipelining, start ignored while busy.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
  logic         m_zf = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  int           left = 0;

  always @(posedge clock) begin
    int lat;
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_lo = '0; m_hi = '0; m_zf = 1'b0; m_dz = 1'b0; left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      left--;
      if (left == 0) begin
        m_done = 1'b1; m_lo = p_lo; m_hi = p_hi; m_dz = p_dz; m_zf = (p_lo == 0);
      end
    end else if (start) begin
      model_op(selector, in_a, in_b, p_lo, p_hi, p_dz, lat);
      m_busy = 1'b1;
      left   = lat - 1;
      if (left == 0) begin
        m_done = 1'b1; m_lo = p_lo; m_hi = p_hi; m_dz = p_dz; m_zf = (p_lo == 0);
      end
    end
  end

  always @(negedge clock) begin
    chk("cyc_busy", busy, m_busy);
    chk("cyc_done", done, m_done);
    chk("cyc_lo", output_data, m_lo);
    chk("cyc_hi", output_data_hi, m_hi);
    chk("cyc_zero", zeroFlag, m_zf);
    chk("cyc_divzero", divZero, m_dz);
  end

  // Issue one op, wait for done, check latency and hand-computed results.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_lo,
                        input logic [W-1:0] exp_hi, input logic exp_dz, input int ignore_at);
    int cyc;
    bit got;
    @(negedge clock);
    start = 1'b1; selector = op; in_a = a; in_b = b;
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (done) got = 1;
      start = 1'b0;
      if (cyc == ignore_at) begin
        start = 1'b1; selector = 3'd0; in_a = 32'd1; in_b = 32'd1;
      end
    end
    start = 1'b0;
    chk({name, ":done_seen"}, got, 1);
    chk({name, ":latency"}, cyc, exp_lat);
    chk({name, ":lo"}, output_data, exp_lo);
    chk({name, ":hi"}, output_data_hi, exp_hi);
    chk({name, ":zero"}, zeroFlag, (exp_lo == 0));
    chk({name, ":divzero"}, divZero, exp_dz);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; selector = 3'd0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_lo", output_data, 0);
    chk("reset_zero", zeroFlag, 0);
    chk("reset_divzero", divZero, 0);
    reset = 1'b0;

    run_op("add_5_7",    3'd0, 32'd5,          32'd7,          1, 32'd12,         32'd0, 1'b0, 0);
    run_op("sub_3_3",    3'd1, 32'd3,          32'd3,          1, 32'd0,          32'd0, 1'b0, 0);
    run_op("and",        3'd2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  1, 32'h00F0_00F0,  32'd0, 1'b0, 0);
    run_op("or",         3'd3, 32'h1234_0000,  32'h0000_5678,  1, 32'h1234_5678,  32'd0, 1'b0, 0);
    run_op("slt_neg",    3'd4, 32'hFFFF_FFFF,  32'd1,          1, 32'd1,          32'd0, 1'b0, 0);
    run_op("slt_pos",    3'd4, 32'd1,          32'hFFFF_FFFF,  1, 32'd0,          32'd0, 1'b0, 0);
    run_op("slt_min",    3'd4, 32'h8000_0000,  32'h7FFF_FFFF,  1, 32'd1,          32'd0, 1'b0, 0);
    run_op("xor",        3'd5, 32'hF0F0_F0F0,  32'hFFFF_FFFF,  1, 32'h0F0F_0F0F,  32'd0, 1'b0, 0);
    run_op("add_wrap",   3'd0, 32'hFFFF_FFFF,  32'd1,          1, 32'd0,          32'd0, 1'b0, 0);
    run_op("sub_wrap",   3'd1, 32'd0,          32'd1,          1, 32'hFFFF_FFFF,  32'd0, 1'b0, 0);

    // A start presented in the done cycle must be dropped.
    start = 1'b1; selector = 3'd0; in_a = 32'd2; in_b = 32'd2;
    @(negedge clock);
    start = 1'b0;
    chk("done_cycle_start:busy", busy, 0);
    chk("done_cycle_start:lo", output_data, 32'hFFFF_FFFF);

    // Reset in the middle of a multiply clears everything on the next cycle.
    start = 1'b1; selector = 3'd6; in_a = 32'd9; in_b = 32'd9;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    chk("midreset:busy", busy, 0);
    chk("midreset:done", done, 0);
    chk("midreset:lo", output_data, 0);
    chk("midreset:hi", output_data_hi, 0);
    chk("midreset:zero", zeroFlag, 0);
    reset = 1'b0;
    run_op("add_1_1",    3'd0, 32'd1,          32'd1,          1, 32'd2,          32'd0, 1'b0, 0);

    run_op("mulu_ign",   3'd6, 32'hFFFF_FFFF,  32'd2,         33, 32'hFFFF_FFFE,  32'd1, 1'b0, 5);
    run_op("mulu_max",   3'd6, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'h0000_0001,  32'hFFFF_FFFE, 1'b0, 0);
    run_op("mulu_zero",  3'd6, 32'd0,          32'd5,         33, 32'd0,          32'd0, 1'b0, 0);

`ifdef ALU_SEQ_DIV_EN
    run_op("divu_100_7", 3'd7, 32'd100,        32'd7,         33, 32'd14,         32'd2, 1'b0, 0);
    run_op("divu_by0",   3'd7, 32'd100,        32'd0,          1, 32'hFFFF_FFFF,  32'd100, 1'b1, 0);
    run_op("divu_by1",   3'd7, 32'hFFFF_FFFF,  32'd1,         33, 32'hFFFF_FFFF,  32'd0, 1'b0, 0);
    run_op("divu_by0_b", 3'd7, 32'd5,          32'd0,          1, 32'hFFFF_FFFF,  32'd5, 1'b1, 0);
    run_op("add_clr_dz", 3'd0, 32'd1,          32'd2,          1, 32'd3,          32'd0, 1'b0, 0);
`else
    run_op("divu_off",   3'd7, 32'd100,        32'd7,          1, 32'd0,          32'd0, 1'b0, 0);
    run_op("divu_off_0", 3'd7, 32'd100,        32'd0,          1, 32'd0,          32'd0, 1'b0, 0);
`endif

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath ALU. Keeps the four single-cycle ops (add, sub, and, or) at the same opcodes and adds signed set-less-than, xor, an iterative unsigned multiply and an iterative unsigned divide. Operation is driven by a start/busy/done handshake. Sits in the execute stage; the control unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; must be ≥ 4.

Ports:
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `selector`  in  3  opcode, sampled with `start`.
- `input_data_A`  in  WIDTH  operand A, sampled with `start`.
- `input_data_B`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; results valid in that cycle.
- `output_data`  out  WIDTH  result (MULU low word, DIVU quotient).
- `output_data_hi`  out  WIDTH  MULU high word, DIVU remainder, 0 for all other ops.
- `zeroFlag`  out  1  `output_data`==0, registered with the result.
- `divZero`  out  1  last completed DIVU had B==0.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR, 110 MULU, 111 DIVU.
- ADD and SUB wrap modulo 2^WIDTH, with no carry or overflow output.
- SLT: signed compare of A and B; result is 1 or 0, zero-extended.
- MULU is radix-2 shift-add over WIDTH iterations. It produces a full 2·WIDTH product: hi goes to `output_data_hi`, lo goes to `output_data`.
- DIVU is restoring division over WIDTH iterations. The quotient goes to `output_data` and the remainder to `output_data_hi`.
- DIVU with B==0 takes a fast path with no iterations: quotient all-ones, remainder = A, `divZero`=1.
- `divZero` updates on every completion: 1 only on the divide-by-zero case, 0 otherwise.
- States and transitions:
  - IDLE: `start` latches opcode and operands. Single-cycle ops and DIVU-by-zero go to DONE. MULU and DIVU go to ITER with iteration counter = WIDTH−1.
  - ITER: one iteration per cycle. The counter decrements; at 0, go to DONE.
  - DONE: result registers load, `done`=1, return to IDLE.
- `busy`=1 in ITER and DONE; `busy`=0 in IDLE.
- `start` while `busy`=1 is ignored and not queued.
- Outputs hold their last completed values until the next DONE.
- Reset, including mid-operation, returns to IDLE and forces all outputs to 0. `zeroFlag` is also 0 after reset; the "result is zero" meaning applies only from the first completion.

## Timing
- `start` is accepted in cycle 0.
- Single-cycle ops and DIVU-by-zero: `done` in cycle 1.
- MULU and DIVU: `done` in cycle WIDTH+1.
- `busy` rises in cycle 1 and falls in the cycle after `done`. The earliest next accepted `start` is one cycle after `done`, so there is no back-to-back issue in the `done` cycle.
- No combinational path from inputs to outputs.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIVU is implemented as above.
- `ALU_SEQ_DIV_EN` undefined:
  - The divider datapath is removed.
  - Opcode 111 completes in cycle 1 with `output_data`=0 and `output_data_hi`=0.
  - `divZero` is held at 0.
  - MULU is unaffected.

## Structure
- Shared package `alu_seq_pkg` holds the opcode constants, the state enum (IDLE, ITER, DONE) and the divide-by-zero quotient constant.
- One sub-module, `alu_seq_muldiv`, holds the iterative shift register pair, the counter and the add/subtract-restore step. It has a mode input and a last-iteration flag.
- The top level holds the FSM, the single-cycle ops and the result registers.

## Test plan
All scenarios use WIDTH=32.
- ADD A=5, B=7 → `done` in cycle 1, `output_data`=12, `zeroFlag`=0. Then SUB A=3, B=3 → `output_data`=0, `zeroFlag`=1.
- SLT A=0xFFFFFFFF, B=1 → `output_data`=1. XOR A=0xF0F0F0F0, B=0xFFFFFFFF → `output_data`=0x0F0F0F0F, `output_data_hi`=0.
- MULU A=0xFFFFFFFF, B=2 → `done` in cycle 33, `output_data`=0xFFFFFFFE, `output_data_hi`=1. A `start` pulse at cycle 5 is ignored and results are unchanged.
- DIVU A=100, B=7 → `done` in cycle 33, quotient 14, remainder 2, `divZero`=0. DIVU A=100, B=0 → `done` in cycle 1, quotient 0xFFFFFFFF, remainder 100, `divZero`=1.
- MULU started, `reset` asserted in cycle 10 → the next cycle shows `busy`=0 and all outputs 0. A new ADD 1+1 → `done` in cycle 1, `output_data`=2.
- With `ALU_SEQ_DIV_EN` undefined, DIVU A=100, B=7 → `done` in cycle 1, `output_data`=0, `output_data_hi`=0, `divZero`=0.
